sinc3_decim_ctrl: RTL and testbench
===================================

// Module: sinc3_decim_ctrl
// PURPOSE
//  Sequencer for a single-bit sinc^3 decimator. Generates the modulator-rate clock enable (mod_en) that drives
//  the sigma-delta modulator and the filter's en input. Counts OSR enables per output word and samples the
//  full-rate filter output at the decimation phase. Discards start-up outputs until the filter is settled, then
//  hands words downstream over valid/ready.
//  Sits between the register block (run/div config) and the sample FIFO/DSP chain.
// PARAMETERS
//  OSR        16  oversampling ratio; must match the filter instance; power of 2, >=4
//  DIV_W      8   width of clock-divider setting
//  SETTLE_DEC 3   decimated outputs discarded after start (sinc^3 needs 3)
//  OVF_W      8   width of overrun counter (only with SINC3_CTRL_OVF_CNT_EN)
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          asynchronous active-low reset
//  run        in   1          level; 1 = acquire, 0 = stop
//  div        in   DIV_W      mod_en period minus 1, in clk cycles; latched at start
//  mod_en     out  1          one-cycle enable to modulator and filter en
//  filt_in    in   W          signed filter output, W = 3*$clog2(OSR)+1
//  dout       out  W          signed decimated sample
//  dout_valid out  1          dout holds an unconsumed sample
//  dout_ready in   1          downstream accepts
//  settled    out  1          FSM in RUN
//  overrun    out  1          sticky: a sample was dropped
//  ovf_cnt    out  OVF_W      dropped-sample count (macro only)
// BEHAVIOUR
//  Reset: state=IDLE; mod_en, dout_valid, settled and overrun = 0; dout = 0; all counters = 0.
//  FSM IDLE->SETTLE when run=1. SETTLE->RUN after SETTLE_DEC capture strobes are discarded.
//  FSM SETTLE/RUN->IDLE on the cycle after run=0.
//  Start (IDLE->SETTLE): latches div into div_q. Clears div_cnt, phase and overrun (and ovf_cnt).
//  Divider: div_cnt counts 0..div_q and wraps. mod_en=1 when div_cnt==div_q in SETTLE or RUN.
//  Divider: div_q=0 gives mod_en every cycle. mod_en is never asserted in IDLE.
//  Phase: increments on mod_en and wraps OSR-1->0. cap_pre = mod_en && phase==OSR-1.
//  Capture: cap_stb = cap_pre registered by one cycle, so the filter register has updated.
//  Capture: on cap_stb the block samples filt_in. Latency is 1 clk from the decimating mod_en.
//  SETTLE: cap_stb increments settle_cnt only; no output. SETTLE_DEC=0 means straight to RUN.
//  Handshake: transfer occurs when dout_valid && dout_ready. dout is stable while valid && !ready.
//  RUN, cap_stb with (!dout_valid || dout_ready): dout<=filt_in, dout_valid<=1.
//  This includes simultaneous transfer and capture: no bubble, no overrun.
//  RUN, cap_stb with dout_valid && !dout_ready: new sample dropped, old one kept, overrun<=1.
//  Transfer without cap_stb: dout_valid<=0.
//  Stop (run=0): mod_en ceases at once. A held dout stays valid until consumed. A cap_stb pending from the
//  last mod_en is ignored.
//  Restart mid-operation (run 1->0->1): full re-settle. Phase resets; the filter's state is not reset.
//  rst_n low at any time: async return to the reset state above.
// CONFIGURATION
//  SINC3_CTRL_OVF_CNT_EN defined: ovf_cnt increments on each dropped sample and saturates at 2^OVF_W-1.
//  SINC3_CTRL_OVF_CNT_EN defined: ovf_cnt clears on start.
//  SINC3_CTRL_OVF_CNT_EN undefined: ovf_cnt port tied to 0; no counter logic; overrun flag still present.
// STRUCTURE
//  Package sinc3_ctrl_pkg: state enum {IDLE,SETTLE,RUN}; function out_width(osr)=3*$clog2(osr)+1.
//  Sub-module sinc3_clk_div (div_cnt + mod_en generation), reusable by other modulator front-ends.
//  FSM, phase counter, capture and output register live in the top.
// TESTING (OSR=16, SETTLE_DEC=3, bench filter model = behavioural sinc^3)
//  div=3, run=1: mod_en every 4 clks. First dout_valid at capture #4 (~4*16*4 clks). Then one word per 64 clks.
//  div=0, constant '1' input, ready=1: after settle, dout = +2048 every 16 clks; settled=1.
//  ready=0 across 2 captures: dout keeps 1st word; overrun=1; ovf_cnt=1 (macro on) or 0 (macro off).
//  dout_ready asserted exactly on a cap_stb cycle: new word loaded; valid stays 1; overrun stays 0.
//  run dropped mid-RUN with valid word pending: mod_en stops next clk; word still transfers on ready.
//  Rerun repeats 3-word settle.
//  rst_n pulsed low mid-SETTLE: all outputs 0 immediately; no mod_en until run is seen again.

Source files
------------

// File: rtl/sinc3_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sinc3_ctrl_pkg
// Shared types and helpers for the sinc^3 decimator sequencer.
//   state_t    : sequencer state (IDLE, SETTLE, RUN)
//   out_width  : width of a sinc^3 decimator output word for a given OSR,
//                3*log2(OSR)+1 bits (signed).
// ----------------------------------------------------------------------------
package sinc3_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    function automatic int out_width(input int osr);
        return 3 * $clog2(osr) + 1;
    endfunction

endpackage

// File: rtl/sinc3_clk_div.sv
// ----------------------------------------------------------------------------
// sinc3_clk_div
// Programmable clock-enable generator for a modulator front-end. While en is
// high, div_cnt counts 0..div_q and wraps; mod_en pulses for one clk on the
// terminal count, giving one pulse every div_q+1 clks (div_q = 0 -> every clk).
// mod_en is never asserted while en is low.
//
// Ports
//   clk     in   1       system clock
//   rst_n   in   1       asynchronous active-low reset
//   en      in   1       divider running
//   clr     in   1       synchronous restart of the count (priority over en)
//   div_q   in   DIV_W   period minus 1, in clk cycles
//   mod_en  out  1       one-cycle enable pulse
// ----------------------------------------------------------------------------
module sinc3_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_q,
    output logic             mod_en
);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    assign terminal = (div_cnt == div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= terminal ? '0 : div_cnt + 1'b1;
        end
    end

    // Combinational from registers only, so the pulse is glitch-free and
    // drops in the same cycle the enable is withdrawn.
    assign mod_en = en && terminal;

endmodule

// File: rtl/sinc3_decim_ctrl.sv
// ----------------------------------------------------------------------------
// sinc3_decim_ctrl
// Sequencer for a single-bit sinc^3 decimator. Produces the modulator-rate
// enable (mod_en) for the modulator and the filter's en input, counts OSR
// enables per output word, samples the full-rate filter output one clk after
// the decimating enable, throws away the start-up words while the filter
// settles, and then offers words downstream over valid/ready.
//
// Build option
//   SINC3_CTRL_OVF_CNT_EN : when defined, ovf_cnt counts dropped samples
//                           (saturating, cleared on start). When undefined,
//                           ovf_cnt is tied to 0; the sticky overrun flag
//                           is present in both builds.
//
// Ports
//   clk         in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   run         in   1       level: 1 = acquire, 0 = stop
//   div         in   DIV_W   mod_en period minus 1 (clks), latched at start
//   mod_en      out  1       one-cycle enable to modulator and filter
//   filt_in     in   W       signed full-rate filter output, W=3*log2(OSR)+1
//   dout        out  W       signed decimated sample
//   dout_valid  out  1       dout holds an unconsumed sample
//   dout_ready  in   1       downstream accepts
//   settled     out  1       sequencer is in RUN
//   overrun     out  1       sticky: a sample was dropped
//   ovf_cnt     out  OVF_W   dropped-sample count (build option only)
// ----------------------------------------------------------------------------
module sinc3_decim_ctrl
    import sinc3_ctrl_pkg::*;
#(
    parameter int OSR        = 16,
    parameter int DIV_W      = 8,
    parameter int SETTLE_DEC = 3,
    parameter int OVF_W      = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run,
    input  logic [DIV_W-1:0]                 div,
    output logic                             mod_en,
    input  logic signed [out_width(OSR)-1:0] filt_in,
    output logic signed [out_width(OSR)-1:0] dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             settled,
    output logic                             overrun,
    output logic [OVF_W-1:0]                 ovf_cnt
);

    localparam int PH_W  = $clog2(OSR);
    localparam int SET_W = (SETTLE_DEC > 1) ? $clog2(SETTLE_DEC) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_DEC - 1);

    state_t           state;
    state_t           state_next;
    logic             start;
    logic             active;
    logic [DIV_W-1:0] div_q;
    logic [PH_W-1:0]  phase;
    logic             cap_pre;
    logic             cap_stb;
    logic [SET_W-1:0] settle_cnt;
    logic             cap_run;
    logic             drop;

    // ------------------------------------------------------------------
    // Modulator-rate enable
    // ------------------------------------------------------------------
    assign active = (state != IDLE);

    sinc3_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (active),
        .clr    (start),
        .div_q  (div_q),
        .mod_en (mod_en)
    );

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    start      = 1'b1;
                    // With nothing to discard the filter is treated as
                    // settled from the first decimated word.
                    state_next = (SETTLE_DEC == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (cap_stb && (settle_cnt == SET_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, configuration latch, phase and settle counting
    // ------------------------------------------------------------------
    // The decimating enable is the last of OSR enables. The filter register
    // only takes that sample at the end of the enable cycle, so the capture
    // strobe is delayed one clk to sample the updated output.
    assign cap_pre = mod_en && (phase == PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_q      <= '0;
            phase      <= '0;
            cap_stb    <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state   <= state_next;
            cap_stb <= cap_pre;
            if (start) begin
                div_q      <= div;
                phase      <= '0;
                settle_cnt <= '0;
                cap_stb    <= 1'b0;
            end else begin
                if (mod_en) begin
                    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                end
                if ((state == SETTLE) && cap_stb) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    // Only captures taken in RUN reach the output; a strobe left over from
    // the last enable before a stop lands in IDLE and is ignored. The held
    // word keeps its valid through a stop until it is consumed.
    assign cap_run = cap_stb && (state == RUN);
    assign drop    = cap_run && dout_valid && !dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start) begin
                overrun <= 1'b0;
            end
            if (cap_run) begin
                if (!dout_valid || dout_ready) begin
                    // Covers back-to-back transfer and reload: no bubble.
                    dout       <= filt_in;
                    dout_valid <= 1'b1;
                end else begin
                    // Keep the unread word; the new one is lost.
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

    assign settled = (state == RUN);

    // ------------------------------------------------------------------
    // Dropped-sample counter
    // ------------------------------------------------------------------
`ifdef SINC3_CTRL_OVF_CNT_EN
    logic [OVF_W-1:0] ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (start) begin
            ovf_q <= '0;
        end else if (drop && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    logic drop_unused;
    assign drop_unused = drop;
    assign ovf_cnt     = '0;
`endif

endmodule

// File: tb/tb_sinc3_decim_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sinc3_decim_ctrl
// Randomized bench for sinc3_decim_ctrl (OSR=16, SETTLE_DEC=3). A behavioural
// sinc^3 filter sits on mod_en/filt_in. A reference model works from the
// rules for the enable period, decimation, settling and the output slot and
// queues expected words; a monitor compares every cycle and pops a word on
// each transfer.
// ----------------------------------------------------------------------------
module tb_sinc3_decim_ctrl;

    localparam int OSR        = 16;
    localparam int DIV_W      = 8;
    localparam int SETTLE_DEC = 3;
    localparam int OVF_W      = 8;
    localparam int W          = 3 * $clog2(OSR) + 1;
    localparam int L          = 3 * OSR - 2;
    localparam int HALF       = OSR * OSR * OSR / 2;
    localparam int NRND       = 4096;
    localparam int NBITS      = 8192;
    localparam int OVF_MAX    = (1 << OVF_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 run;
    logic [DIV_W-1:0]     div;
    logic                 mod_en;
    logic signed [W-1:0]  filt_in = '0;
    logic signed [W-1:0]  dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 settled;
    logic                 overrun;
    logic [OVF_W-1:0]     ovf_cnt;

    int checks   = 0;
    int errors   = 0;
    int xfer_cnt = 0;

    bit const_mode  = 1'b0;
    bit const_check = 1'b0;
    int kern [L];
    bit rnd  [NRND];

    // reference model state
    bit m_active   = 1'b0;
    bit m_cap_pend = 1'b0;
    bit m_slot     = 1'b0;
    bit m_ovr      = 1'b0;
    int m_cyc      = 0;
    int m_dq       = 0;
    int m_total    = 0;
    int m_runmods  = 0;
    int m_dec      = 0;
    int m_ovf      = 0;
    int m_pend_val = 0;
    bit mbits [NBITS];
    int exp_q [$];

    sinc3_decim_ctrl #(
        .OSR        (OSR),
        .DIV_W      (DIV_W),
        .SETTLE_DEC (SETTLE_DEC),
        .OVF_W      (OVF_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .div        (div),
        .mod_en     (mod_en),
        .filt_in    (filt_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .settled    (settled),
        .overrun    (overrun),
        .ovf_cnt    (ovf_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // sinc^3 output after n modulator bits, offset so all-ones gives +HALF
    function automatic int ref_sinc3(input int n);
        int acc = -HALF;
        for (int i = 0; i < L; i++) begin
            if (n - 1 - i >= 0) acc += kern[i] * int'(mbits[n - 1 - i]);
        end
        return acc;
    endfunction

    // ---------------- behavioural filter (environment) ----------------
    initial begin : filter_env
        int hist [L];
        int e_total;
        bit men;
        int y;
        for (int i = 0; i < L; i++) hist[i] = 0;
        e_total = 0;
        forever begin
            @(negedge clk);
            men = mod_en;
            @(posedge clk);
            if (men) begin
                for (int i = L - 1; i > 0; i--) hist[i] = hist[i - 1];
                hist[0] = (const_mode || rnd[e_total % NRND]) ? 1 : 0;
                e_total++;
                y = -HALF;
                for (int i = 0; i < L; i++) y += kern[i] * hist[i];
                filt_in <= W'(y);
            end
        end
    end

    // ---------------- reference model ----------------
    initial begin : ref_model
        bit men, cap, cap_run;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active   = 1'b0;
                m_cap_pend = 1'b0;
                m_slot     = 1'b0;
                m_ovr      = 1'b0;
                m_cyc      = 0;
                m_dq       = 0;
                m_runmods  = 0;
                m_dec      = 0;
                m_ovf      = 0;
                exp_q.delete();
            end else begin
                men     = m_active && (m_cyc == m_dq);
                cap     = m_cap_pend && m_active;
                cap_run = cap && (m_dec >= SETTLE_DEC);
                if (cap_run) begin
                    if (!m_slot || dout_ready) begin
                        exp_q.push_back(m_pend_val);
                        m_slot = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                        if (m_ovf < OVF_MAX) m_ovf++;
                    end
                end else if (m_slot && dout_ready) begin
                    m_slot = 1'b0;
                end
                if (cap && !cap_run) m_dec++;
                m_cap_pend = 1'b0;
                if (men && m_total < NBITS) begin
                    mbits[m_total] = const_mode || rnd[m_total % NRND];
                    m_total++;
                    m_runmods++;
                    if (m_runmods % OSR == 0) begin
                        m_cap_pend = 1'b1;
                        m_pend_val = ref_sinc3(m_total);
                    end
                end
                if (m_active) m_cyc = (m_cyc == m_dq) ? 0 : m_cyc + 1;
                if (!m_active && run) begin
                    m_active   = 1'b1;
                    m_cyc      = 0;
                    m_dq       = int'(div);
                    m_runmods  = 0;
                    m_dec      = 0;
                    m_ovr      = 1'b0;
                    m_ovf      = 0;
                    m_cap_pend = 1'b0;
                end else if (m_active && !run) begin
                    m_active = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        int exp_v;
        int exp_ovf;
        forever begin
            @(negedge clk);
            if (rst_n) begin
`ifdef SINC3_CTRL_OVF_CNT_EN
                exp_ovf = m_ovf;
`else
                exp_ovf = 0;
`endif
                chk("mod_en", mod_en, m_active && (m_cyc == m_dq));
                chk("dout_valid", dout_valid, m_slot);
                chk("settled", settled, m_active && (m_dec >= SETTLE_DEC));
                chk("overrun", overrun, m_ovr);
                chk("ovf_cnt", ovf_cnt, exp_ovf);
                if (dout_valid && dout_ready) begin
                    chk("word_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_v = exp_q.pop_front();
                        xfer_cnt++;
                        $display("xfer %0d: dout=%0d expected=%0d t=%0t", xfer_cnt, dout, exp_v, $time);
                        chk("dout", dout, exp_v);
                        if (const_check) chk("dout_const_ones", dout, 2048);
                    end
                end
            end
        end
    end

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!dout_valid && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, dout_valid, 1);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, xfer_cnt >= target, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int k2 [2*OSR-1];
        int n;
        int base;

        for (int i = 0; i < 2*OSR-1; i++) k2[i] = 0;
        for (int a = 0; a < OSR; a++)
            for (int b = 0; b < OSR; b++) k2[a+b]++;
        for (int i = 0; i < L; i++) kern[i] = 0;
        for (int a = 0; a < 2*OSR-1; a++)
            for (int b = 0; b < OSR; b++) kern[a+b] += k2[a];
        for (int i = 0; i < NRND; i++) rnd[i] = 1'($urandom);

        rst_n      = 1'b0;
        run        = 1'b0;
        div        = 8'd3;
        dout_ready = 1'b1;
        tick(3);
        chk("rst_mod_en", mod_en, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_settled", settled, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        // div=3, random bits: enable every 4 clks, first word at capture #4
        base = xfer_cnt;
        run  = 1'b1;
        wait_valid("a_valid_timeout", 400, n);
        chk("a_first_valid_latency", n, 258);
        wait_xfers("a_words", base + 6, 6 * 64 + 50);

        // div=0, constant ones: +2048 every 16 clks once settled
        run = 1'b0;
        tick(3);
        chk("b_stopped_settled", settled, 0);
        div         = 8'd0;
        const_mode  = 1'b1;
        const_check = 1'b1;
        base        = xfer_cnt;
        run         = 1'b1;
        wait_xfers("b_words", base + 6, 300);
        chk("b_settled", settled, 1);
        const_check = 1'b0;
        run         = 1'b0;
        tick(2);
        const_mode = 1'b0;

        // ready low across captures: first word kept, later ones dropped
        dout_ready = 1'b0;
        run        = 1'b1;
        wait_valid("c_valid_timeout", 200, n);
        tick(20);
        chk("c_overrun", overrun, 1);
`ifdef SINC3_CTRL_OVF_CNT_EN
        chk("c_ovf_cnt", ovf_cnt, 1);
`else
        chk("c_ovf_cnt", ovf_cnt, 0);
`endif
        chk("c_valid_held", dout_valid, 1);
        base       = xfer_cnt;
        dout_ready = 1'b1;
        wait_xfers("c_drain", base + 1, 5);

        // ready raised exactly in a capture cycle: reload, no overrun
        run = 1'b0;
        tick(2);
        dout_ready = 1'b0;
        run        = 1'b1;
        wait_valid("d_valid_timeout", 200, n);
        n = 0;
        while (!(m_cap_pend && m_active && m_dec >= SETTLE_DEC) && n < 40) begin
            tick(1);
            n++;
        end
        chk("d_cap_cycle_found", n < 40, 1);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        chk("d_overrun_clear", overrun, 0);
        chk("d_valid_kept", dout_valid, 1);
        dout_ready = 1'b1;
        tick(3);

        // stop with a word pending: enables cease, word still drains
        dout_ready = 1'b0;
        wait_valid("e_valid_timeout", 40, n);
        run = 1'b0;
        tick(1);
        chk("e_mod_en_stopped", mod_en, 0);
        tick(5);
        chk("e_valid_held", dout_valid, 1);
        base       = xfer_cnt;
        dout_ready = 1'b1;
        wait_xfers("e_drain", base + 1, 5);
        tick(1);
        chk("e_drained", dout_valid, 0);

        // async reset mid-settle, then a full re-settle
        div = 8'd3;
        run = 1'b1;
        tick(30);
        chk("f_settling", settled, 0);
        rst_n = 1'b0;
        #1;
        chk("f_rst_mod_en", mod_en, 0);
        chk("f_rst_dout", dout, 0);
        chk("f_rst_dout_valid", dout_valid, 0);
        chk("f_rst_settled", settled, 0);
        chk("f_rst_overrun", overrun, 0);
        chk("f_rst_ovf_cnt", ovf_cnt, 0);
        run = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("f_no_mod_en", mod_en, 0);
        div  = 8'd0;
        base = xfer_cnt;
        run  = 1'b1;
        wait_xfers("f_words", base + 2, 200);
        run = 1'b0;
        tick(5);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
